// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-field constants for the data cache.
//   state_t       - controller states
//   *_W / *_LSB   - widths and positions of the tag/index/offset fields
//   byte_of()     - selects one byte lane out of a cache line
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;

  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

  localparam int LINE_W = 8 * (1 << OFFSET_W);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  function automatic logic [7:0] byte_of(input logic [LINE_W-1:0] line,
                                         input logic [OFFSET_W-1:0] offset);
    return line[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage for the direct-mapped cache.
//   clk, rst        - clock, async active-high reset (clears valid and dirty)
//   rd_index        - combinational read port index
//   rd_valid/dirty/tag/data - state of the indexed line
//   wr_en           - synchronous write strobe
//   wr_fill         - 1: whole-line fill (valid=1, dirty=0, new tag)
//                     0: single byte store at wr_offset (dirty=1)
//   wr_index, wr_offset, wr_byte, wr_line, wr_tag - write payload
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_W-1:0]       rd_index,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [8*BLOCK_BYTES-1:0] rd_data,
  input  logic                     wr_en,
  input  logic                     wr_fill,
  input  logic [INDEX_W-1:0]       wr_index,
  input  logic [OFFSET_W-1:0]      wr_offset,
  input  logic [7:0]               wr_byte,
  input  logic [8*BLOCK_BYTES-1:0] wr_line,
  input  logic [TAG_W-1:0]         wr_tag
);

  logic [NUM_BLOCKS-1:0]    valid;
  logic [NUM_BLOCKS-1:0]    dirty;
  logic [TAG_W-1:0]         tag_mem  [NUM_BLOCKS];
  logic [8*BLOCK_BYTES-1:0] data_mem [NUM_BLOCKS];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  // Only the status bits need reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      if (wr_fill) begin
        valid[wr_index] <= 1'b1;
        dirty[wr_index] <= 1'b0;
      end else begin
        dirty[wr_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_mem[wr_index]  <= wr_tag;
        data_mem[wr_index] <= wr_line;
      end else begin
        data_mem[wr_index][{wr_offset, 3'b000} +: 8] <= wr_byte;
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back data cache between the CPU and main memory.
//   CLK, RESET      - clock, async active-high reset
//   READ, WRITE     - CPU load/store request, held while BUSYWAIT is high
//   ADDRESS         - byte address {tag, index, offset}
//   WRITEDATA       - store data; READDATA - load data (combinational on hit)
//   BUSYWAIT        - CPU stall
//   MEM_READ/WRITE  - block fetch / writeback request (registered)
//   MEM_ADDRESS     - block address {tag, index}
//   MEM_WRITEDATA   - victim line; MEM_READDATA - fetched line
//   MEM_BUSYWAIT    - main memory busy
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | serving hits; a miss leaves for WRITEBACK or FETCH
// WRITEBACK | dirty victim being written to memory (MEM_WRITE=1)
// FETCH     | requested block being read from memory (MEM_READ=1)
// UPDATE    | fetched block written into the line, then back to IDLE
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        ADDRESS,
  input  logic [7:0]               WRITEDATA,
  output logic [7:0]               READDATA,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0] MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0] MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  state_t state;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;

  logic                     line_valid;
  logic                     line_dirty;
  logic [TAG_W-1:0]         line_tag;
  logic [8*BLOCK_BYTES-1:0] line_data;
  logic [8*BLOCK_BYTES-1:0] fill_buf;

  logic req;
  logic hit;
  logic wr_en;
  logic wr_fill;

  assign addr_tag    = ADDRESS[TAG_LSB    +: TAG_W];
  assign addr_index  = ADDRESS[INDEX_LSB  +: INDEX_W];
  assign addr_offset = ADDRESS[OFFSET_LSB +: OFFSET_W];

  assign req = READ | WRITE;
  assign hit = line_valid && (line_tag == addr_tag);

  assign BUSYWAIT = req && !(state == IDLE && hit);
  assign READDATA = byte_of(line_data, addr_offset);

  // READ and WRITE together fall through to the store path here.
  assign wr_fill = (state == UPDATE);
  assign wr_en   = wr_fill || (state == IDLE && WRITE && hit);

  assign MEM_ADDRESS   = (state == WRITEBACK) ? {line_tag, addr_index}
                                              : {addr_tag, addr_index};
  assign MEM_WRITEDATA = line_data;

  // The fetched block is captured on the edge memory completes, so the fill
  // does not depend on memory holding its read data afterwards.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;
      fill_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state     <= WRITEBACK;
              MEM_WRITE <= 1'b1;
            end else begin
              state    <= FETCH;
              MEM_READ <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state     <= FETCH;
            MEM_WRITE <= 1'b0;
            MEM_READ  <= 1'b1;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state    <= UPDATE;
            MEM_READ <= 1'b0;
            fill_buf <= MEM_READDATA;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

  dcache_array #(
    .NUM_BLOCKS  (NUM_BLOCKS),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_array (
    .clk       (CLK),
    .rst       (RESET),
    .rd_index  (addr_index),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_fill   (wr_fill),
    .wr_index  (addr_index),
    .wr_offset (addr_offset),
    .wr_byte   (WRITEDATA),
    .wr_line   (fill_buf),
    .wr_tag    (addr_tag)
  );

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache with a behavioural 5-cycle main memory,
// a read-data scoreboard queue and a log of memory-side transactions.
module tb_dcache;
  import dcache_pkg::*;

  localparam int MEM_LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // ---------------- behavioural main memory ----------------
  logic [31:0] mem [64];
  int          mem_cnt;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < MEM_LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) mem_cnt <= 0;
    else if (MEM_READ | MEM_WRITE) mem_cnt <= (mem_cnt >= MEM_LAT) ? 0 : mem_cnt + 1;
    else mem_cnt <= 0;
  end

  always @(posedge CLK) begin
    if (!RESET && MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] = MEM_WRITEDATA;
  end

  // ---------------- memory-side monitor ----------------
  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mon_t;

  mon_t mon_q[$];
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge CLK) begin
    compared++;
    assert ((MEM_READ & MEM_WRITE) === 1'b0)
    else begin
      mismatched++;
      $error("FAIL mem_excl observed rd=%b wr=%b expected not both", MEM_READ, MEM_WRITE);
    end
    if (!RESET && MEM_WRITE && !prev_wr) mon_q.push_back('{1'b1, MEM_ADDRESS, MEM_WRITEDATA});
    if (!RESET && MEM_READ && !prev_rd)  mon_q.push_back('{1'b0, MEM_ADDRESS, 32'h0});
    prev_rd = MEM_READ;
    prev_wr = MEM_WRITE;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] init_byte(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'hC3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input int exp_stall, input string tag);
    int stall;
    logic [7:0] want;
    @(negedge CLK);
    READ      = !wr;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = wdata;
    if (wr) ref_mem[addr] = wdata;
    else    exp_q.push_back(ref_mem[addr]);
    #1;
    stall = 0;
    while (BUSYWAIT && stall < 200) begin
      @(negedge CLK);
      #1;
      stall++;
    end
    chk({tag, "_stall"}, stall, exp_stall);
    if (!wr) begin
      want = exp_q.pop_front();
      chk({tag, "_data"}, {24'h0, READDATA}, {24'h0, want});
    end
    @(posedge CLK);
    #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  task automatic expect_log(input bit is_wr, input logic [5:0] addr,
                            input logic [31:0] data, input string tag);
    mon_t m;
    if (mon_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      m = mon_q.pop_front();
      chk({tag, "_kind"}, {31'h0, m.is_wr}, {31'h0, is_wr});
      chk({tag, "_addr"}, {26'h0, m.addr}, {26'h0, addr});
      if (is_wr) chk({tag, "_wdata"}, m.data, data);
    end
  endtask

  task automatic expect_log_empty(input string tag);
    chk({tag, "_nolog"}, mon_q.size(), 32'd0);
  endtask

  task automatic resync_ref();
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a[7:2]][{a[1:0], 3'b000} +: 8];
  endtask

  logic [31:0] victim;

  initial begin
    for (int b = 0; b < 64; b++)
      for (int i = 0; i < 4; i++) mem[b][8*i +: 8] = init_byte(b * 4 + i);
    for (int a = 0; a < 256; a++) ref_mem[a] = init_byte(a);

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busywait", {31'h0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'h0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'h0, MEM_WRITE}, 32'd0);
    RESET = 1'b0;

    // cold miss: 1 IDLE + 6 FETCH + 1 UPDATE stall cycles
    access(1'b0, 8'h00, 8'h00, 8, "rd00_miss");
    expect_log(1'b0, 6'h00, 32'h0, "rd00_fetch");
    access(1'b0, 8'h04, 8'h00, 8, "rd04_miss");
    expect_log(1'b0, 6'h01, 32'h0, "rd04_fetch");

    // hits do not stall
    access(1'b1, 8'h05, 8'hAB, 0, "wr05_hit");
    access(1'b0, 8'h05, 8'h00, 0, "rd05_hit");
    access(1'b1, 8'h04, 8'h5A, 0, "wr04_hit");
    expect_log_empty("hits");

    // dirty eviction: 6 WRITEBACK cycles in front of the clean-miss stall
    victim = {ref_mem[8'h07], ref_mem[8'h06], ref_mem[8'h05], ref_mem[8'h04]};
    access(1'b0, 8'h24, 8'h00, 14, "rd24_dirty");
    expect_log(1'b1, 6'h01, victim, "rd24_wb");
    expect_log(1'b0, 6'h09, 32'h0, "rd24_fetch");

    // clean eviction: fetch only
    access(1'b0, 8'h08, 8'h00, 8, "rd08_miss");
    expect_log(1'b0, 6'h02, 32'h0, "rd08_fetch");
    access(1'b0, 8'h28, 8'h00, 8, "rd28_clean");
    expect_log(1'b0, 6'h0A, 32'h0, "rd28_fetch");
    expect_log_empty("rd28");

    // the written-back block comes back intact
    access(1'b0, 8'h04, 8'h00, 8, "rd04_refetch");
    expect_log(1'b0, 6'h01, 32'h0, "rd04_refetch_f");
    access(1'b0, 8'h05, 8'h00, 0, "rd05_refetch");

    // write miss allocates, then stores
    access(1'b1, 8'h31, 8'h77, 8, "wr31_miss");
    expect_log(1'b0, 6'h0C, 32'h0, "wr31_fetch");
    access(1'b0, 8'h31, 8'h00, 0, "rd31_hit");

    // idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      chk("idle_busywait", {31'h0, BUSYWAIT}, 32'd0);
      chk("idle_mem_req", {31'h0, MEM_READ | MEM_WRITE}, 32'd0);
    end

    // reset in the middle of a fetch
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h48;
    repeat (3) @(negedge CLK);
    #1;
    chk("midfetch_mem_read", {31'h0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_mem_read", {31'h0, MEM_READ}, 32'd0);
    chk("abort_mem_write", {31'h0, MEM_WRITE}, 32'd0);
    chk("abort_state", {30'h0, dut.state}, {30'h0, IDLE});
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    expect_log(1'b0, 6'h12, 32'h0, "abort_fetch");
    resync_ref();

    // everything misses again; the dirty 0x77 store was discarded by reset
    access(1'b0, 8'h48, 8'h00, 8, "rd48_after_rst");
    expect_log(1'b0, 6'h12, 32'h0, "rd48_fetch");
    access(1'b0, 8'h31, 8'h00, 8, "rd31_after_rst");
    chk("rd31_lost_store", {24'h0, ref_mem[8'h31]}, {24'h0, init_byte(8'h31)});
    expect_log(1'b0, 6'h0C, 32'h0, "rd31_fetch");
    access(1'b0, 8'h05, 8'h00, 8, "rd05_after_rst");
    expect_log(1'b0, 6'h01, 32'h0, "rd05_fetch");
    expect_log_empty("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
